// File: rtl/hbram_arb_pkg.sv
// HyperRAM command arbiter: shared types and constants.
// Optional urgent-bypass build: HBRAM_ARB_URGENT_EN.
package hbram_arb_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_BUSY,
    S_WAIT_IDLE,
    S_DONE
  } arb_state_e;

  localparam int unsigned HW_PER_BEAT = 2;

  function automatic bit is_pow2(input int unsigned v);
    return (v >= 2) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/hbram_cmd_arbiter_if.sv
// Command channels plus HyperRAM native control port.
// ch_urgent exists only with HBRAM_ARB_URGENT_EN.
interface hbram_cmd_arbiter_if #(
  parameter int CH_NUM     = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int LEN_WIDTH  = 11
);
  logic [CH_NUM-1:0]            ch_req;
  logic [CH_NUM-1:0]            ch_rw;
  logic [CH_NUM*ADDR_WIDTH-1:0] ch_addr;
  logic [CH_NUM*LEN_WIDTH-1:0]  ch_len;
  logic [CH_NUM-1:0]            ch_ack;
  logic [CH_NUM-1:0]            ch_grant;
  logic [CH_NUM-1:0]            ch_done;
`ifdef HBRAM_ARB_URGENT_EN
  logic [CH_NUM-1:0]            ch_urgent;
`endif
  logic                         hbc_cal_pass;
  logic                         ctrl_idle;
  logic                         ram_en;
  logic                         rw_ctrl;
  logic [ADDR_WIDTH-1:0]        ram_addr;
  logic [LEN_WIDTH-1:0]         ram_burst_len;
  logic                         arb_busy;

  modport slave (
`ifdef HBRAM_ARB_URGENT_EN
    input  ch_urgent,
`endif
    input  ch_req, ch_rw, ch_addr, ch_len,
    input  hbc_cal_pass, ctrl_idle,
    output ch_ack, ch_grant, ch_done,
    output ram_en, rw_ctrl, ram_addr,
    output ram_burst_len, arb_busy
  );

  modport master (
`ifdef HBRAM_ARB_URGENT_EN
    output ch_urgent,
`endif
    output ch_req, ch_rw, ch_addr, ch_len,
    output hbc_cal_pass, ctrl_idle,
    input  ch_ack, ch_grant, ch_done,
    input  ram_en, rw_ctrl, ram_addr,
    input  ram_burst_len, arb_busy
  );
endinterface

// File: rtl/hbram_rr_arbiter.sv
// One-hot round-robin pick: first requester after ptr wins.
module hbram_rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt
);
  logic [PW-1:0] idx;

  // Walk from farthest to nearest so the nearest requester lands last.
  always_comb begin
    gnt = '0;
    idx = '0;
    for (int k = N; k >= 1; k--) begin
      idx = PW'((int'(ptr) + k) % N);
      if (req[idx]) gnt = N'(1) << idx;
    end
  end
endmodule

// File: rtl/hbram_cmd_arbiter.sv
// Round-robin command front-end splitting bursts at MAX_BURST/BOUNDARY.
// Optional urgent-bypass build: HBRAM_ARB_URGENT_EN.
module hbram_cmd_arbiter
  import hbram_arb_pkg::*;
#(
  parameter int CH_NUM     = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int LEN_WIDTH  = 11,
  parameter int MAX_BURST  = 128,
  parameter int BOUNDARY   = 1024
) (
  input logic                ram_clock,
  input logic                ram_reset_n,
  hbram_cmd_arbiter_if.slave bus
);
  localparam int PW = $clog2(CH_NUM);
  localparam int BW = $clog2(BOUNDARY) + 1;

  if (!is_pow2(BOUNDARY)) begin : g_bad_boundary
    $error("BOUNDARY must be a power of two >= 2");
  end

  arb_state_e            state_q, state_d;
  logic [PW-1:0]         ptr_q, ptr_d;
  logic [PW-1:0]         gidx_q, gidx_d;
  logic [CH_NUM-1:0]     grant_q, grant_d;
  logic [CH_NUM-1:0]     ack_q, ack_d;
  logic                  rw_q, rw_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0]  rem_q, rem_d;
  logic                  ram_en_q, ram_en_d;
  logic                  ram_rw_q, ram_rw_d;
  logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
  logic [LEN_WIDTH-1:0]  ram_len_q, ram_len_d;

  logic [CH_NUM-1:0]     rr_oh;
  logic [CH_NUM-1:0]     pick_oh;
  logic [PW-1:0]         pick_idx;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [LEN_WIDTH-1:0]  cmd_len;
  logic [BW-1:0]         off;
  logic [BW-1:0]         bnd_beats;
  logic [31:0]           sub32;
  logic [LEN_WIDTH-1:0]  sub;

  hbram_rr_arbiter #(.N(CH_NUM), .PW(PW)) u_rr (
    .req (bus.ch_req),
    .ptr (ptr_q),
    .gnt (rr_oh)
  );

  always_comb begin
    pick_oh = rr_oh;
`ifdef HBRAM_ARB_URGENT_EN
    for (int i = CH_NUM - 1; i >= 0; i--) begin
      if (bus.ch_req[i] && bus.ch_urgent[i])
        pick_oh = CH_NUM'(1) << i;
    end
`endif
    pick_idx = '0;
    for (int i = 0; i < CH_NUM; i++) begin
      if (pick_oh[i]) pick_idx = PW'(i);
    end
    cmd_addr = bus.ch_addr[pick_idx*ADDR_WIDTH +: ADDR_WIDTH];
    cmd_len  = bus.ch_len[pick_idx*LEN_WIDTH +: LEN_WIDTH];
  end

  // Sub-burst size comes only from registered state.
  always_comb begin
    off       = {1'b0, addr_q[BW-2:0]};
    bnd_beats = (BW'(BOUNDARY) - off) / BW'(HW_PER_BEAT);
    sub32     = 32'(rem_q);
    if (32'(MAX_BURST) < sub32) sub32 = 32'(MAX_BURST);
    if (32'(bnd_beats) < sub32) sub32 = 32'(bnd_beats);
    sub       = LEN_WIDTH'(sub32);
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    gidx_d     = gidx_q;
    grant_d    = grant_q;
    ack_d      = '0;
    rw_d       = rw_q;
    addr_d     = addr_q;
    rem_d      = rem_q;
    ram_en_d   = 1'b0;
    ram_rw_d   = ram_rw_q;
    ram_addr_d = ram_addr_q;
    ram_len_d  = ram_len_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.hbc_cal_pass && bus.ctrl_idle &&
            (|bus.ch_req)) begin
          ack_d   = pick_oh;
          grant_d = pick_oh;
          gidx_d  = pick_idx;
          rw_d    = bus.ch_rw[pick_idx];
          addr_d  = {cmd_addr[ADDR_WIDTH-1:1], 1'b0};
          rem_d   = cmd_len;
          state_d = (cmd_len != '0) ? S_ISSUE : S_DONE;
        end
      end
      S_ISSUE: begin
        ram_en_d   = 1'b1;
        ram_rw_d   = rw_q;
        ram_addr_d = addr_q;
        ram_len_d  = sub;
        rem_d      = rem_q - sub;
        addr_d     = addr_q + ADDR_WIDTH'(sub32 * HW_PER_BEAT);
        state_d    = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (!bus.ctrl_idle) state_d = S_WAIT_IDLE;
      end
      S_WAIT_IDLE: begin
        if (bus.ctrl_idle)
          state_d = (rem_q != '0) ? S_ISSUE : S_DONE;
      end
      S_DONE: begin
        grant_d = '0;
        ptr_d   = gidx_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge ram_clock or negedge ram_reset_n) begin
    if (!ram_reset_n) begin
      state_q    <= S_IDLE;
      ptr_q      <= PW'(CH_NUM - 1);
      gidx_q     <= '0;
      grant_q    <= '0;
      ack_q      <= '0;
      rw_q       <= 1'b0;
      addr_q     <= '0;
      rem_q      <= '0;
      ram_en_q   <= 1'b0;
      ram_rw_q   <= 1'b0;
      ram_addr_q <= '0;
      ram_len_q  <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      gidx_q     <= gidx_d;
      grant_q    <= grant_d;
      ack_q      <= ack_d;
      rw_q       <= rw_d;
      addr_q     <= addr_d;
      rem_q      <= rem_d;
      ram_en_q   <= ram_en_d;
      ram_rw_q   <= ram_rw_d;
      ram_addr_q <= ram_addr_d;
      ram_len_q  <= ram_len_d;
    end
  end

  assign bus.ch_ack        = ack_q;
  assign bus.ch_grant      = grant_q;
  assign bus.ch_done       = (state_q == S_DONE) ? grant_q : '0;
  assign bus.ram_en        = ram_en_q;
  assign bus.rw_ctrl       = ram_rw_q;
  assign bus.ram_addr      = ram_addr_q;
  assign bus.ram_burst_len = ram_len_q;
  assign bus.arb_busy      = (state_q != S_IDLE);
endmodule
